seg_scan_controller: RTL
========================

Name: seg_scan_controller

Overview:
Sequences the board's 8-digit multiplexed seven-segment display. It takes a 32-bit hex value through a valid/ready load handshake and commits it atomically at frame boundaries, so no frame ever mixes old and new digits. It drives one digit at a time with a refresh prescaler, a guard interval against ghosting, per-digit enables and optional leading-zero blanking. It sits between the counter/datapath logic and the top-level cathode/anode pins.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz slot rate at 100 MHz); must be >= GUARD+2
GUARD, 16, cycles at the start of each slot during which all anodes are off
CNT_W, $clog2(REFRESH_DIV), prescaler width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
value_in  in  32  eight hex nibbles; nibble i goes to digit i (digit 0 = rightmost)
load_valid  in  1  requester has value_in ready
load_ready  out  1  controller can accept a new value
blank_lz  in  1  1 = blank leading-zero digits
digit_enable  in  8  per-digit enable; 0 = digit forced dark
cathode  out  7  segments, active-low; bit0=a … bit6=g
anode  out  8  digit selects, active-low
frame_done  out  1  one-cycle pulse when digit 7's slot ends

Behaviour:
- Reset (synchronous, active-high, takes priority everywhere): prescaler=0, idx=0, shadow=0, pending=0, pending_full=0, anode=8'hFF, cathode=7'h7F, load_ready=1, frame_done=0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps to 0. tick = (prescaler==REFRESH_DIV-1).
- On tick, idx <= idx+1 mod 8. On a tick with idx==7, frame_done=1 for that cycle. This is the frame boundary.
- Handshake: the transfer happens when load_valid && load_ready. On transfer, pending <= value_in, pending_full <= 1, load_ready <= 0. While load_ready=0, value_in and load_valid are ignored.
- Commit: at a frame boundary with registered pending_full=1, shadow <= pending and pending_full <= 0. load_ready becomes 1 on the following cycle.
- A transfer in the same cycle as a boundary lands in pending and commits at the next boundary. A transfer never writes shadow directly.
- Blanking for digit i: blank if digit_enable[i]=0. Also blank if blank_lz=1, i>0, and shadow nibbles i..7 are all zero. Digit 0 is never LZ-blanked.
- Outputs are registered, with 1-cycle latency from prescaler/idx/shadow. anode = 8'hFF if prescaler<GUARD or the digit is blanked; otherwise ~(8'b1<<idx). cathode = 7'h7F when anode=8'hFF; otherwise hex decode of shadow[4*idx+:4].
- Decode (active-low, g..a):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- At most one anode bit is ever low.
- Reset mid-frame discards pending and shadow. Display restarts from digit 0 with shadow=0.

Decomposition:
- Shared package seg_pkg holds:
  - the 16-entry hex->segment constant table
  - SEG_OFF=7'h7F and ANODE_OFF=8'hFF
  - NUM_DIGITS=8
- One combinational sub-module, hex_to_seg7 (4-bit nibble in, 7-bit active-low cathode out), indexed from seg_pkg. It is reused by other display blocks.

Test Plan:
- Bench setting: REFRESH_DIV=4, GUARD=1.
- Reset: hold reset 3 cycles -> anode=8'hFF, cathode=7'h7F, load_ready=1, frame_done=0.
- Basic load: load 32'h0000_0001 with blank_lz=0 and digit_enable=8'hFF. After the next frame_done, the digit 0 slot shows anode=8'hFE/cathode=7'h79, digits 1..7 show 7'h40, and slot cycle 0 has anode=8'hFF.
- Leading-zero blanking: blank_lz=1 with 32'h0000_0F00 -> digits 0,1 show 7'h40, digit 2 shows 7'h0E, and the anode stays 8'hFF during slots 3..7.
- Handshake: transfer 32'h1234_5678 mid-frame, then hold load_valid with 32'hFFFF_FFFF while load_ready=0.
  - The display changes to 12345678 exactly at the next frame_done; FFFFFFFF is never captured.
  - load_ready returns to 1 one cycle after commit.
  - The boundary-coincident transfer case commits one frame later.
- Digit enable: digit_enable=8'h0F for two frames -> anode[7:4] never low, and cathode=7'h7F during slots 4..7.
- Mid-frame reset: reset asserted mid-frame with pending_full=1 -> next frame shows 0 on digit 0 (7'h40) and the pending value never appears.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display blocks: digit count, blanking
// patterns and the active-low hex decode table (bit0=a ... bit6=g).
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg_scan_controller.sv
// 8-digit multiplexed seven-segment scanner with a valid/ready load port whose
// value is committed only at frame boundaries, plus guard time and blanking.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16,
  parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] value_in,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        blank_lz,
  input  logic [7:0]  digit_enable,
  output logic [6:0]  cathode,
  output logic [7:0]  anode,
  output logic        frame_done
);

  logic [CNT_W-1:0]      r_presc;
  logic [2:0]            r_idx;
  logic [31:0]           r_shadow;
  logic [31:0]           r_pending;
  logic                  r_pending_full;
  logic                  r_load_ready;
  logic                  r_commit_p1;
  logic [7:0]            r_anode_p1;
  logic [6:0]            r_cathode_p1;

  logic                  w_tick;
  logic                  w_boundary;
  logic                  w_transfer;
  logic                  w_commit;
  logic [NUM_DIGITS-1:0] w_nz_from;
  logic                  w_blank;
  logic                  w_dark;
  logic [3:0]            w_nibble;
  logic [6:0]            w_seg;

  assign w_tick     = (r_presc == CNT_W'(REFRESH_DIV - 1));
  assign w_boundary = w_tick & (r_idx == 3'd7);
  assign w_transfer = load_valid & r_load_ready;
  assign w_commit   = w_boundary & r_pending_full;

  // w_nz_from[i]: some nibble from i up to the top digit is non-zero.
  always_comb begin
    w_nz_from = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_nz_from[i] = |(r_shadow >> (4 * i));
    end
  end

  assign w_blank  = ~digit_enable[r_idx]
                  | (blank_lz & (r_idx != 3'd0) & ~w_nz_from[r_idx]);
  assign w_dark   = (r_presc < CNT_W'(GUARD)) | w_blank;
  assign w_nibble = r_shadow[{r_idx, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc        <= '0;
      r_idx          <= '0;
      r_shadow       <= '0;
      r_pending      <= '0;
      r_pending_full <= 1'b0;
      r_load_ready   <= 1'b1;
      r_commit_p1    <= 1'b0;
      r_anode_p1     <= ANODE_OFF;
      r_cathode_p1   <= SEG_OFF;
    end else begin
      r_presc     <= w_tick ? '0 : r_presc + CNT_W'(1);
      r_commit_p1 <= w_commit;
      if (w_tick) r_idx <= r_idx + 3'd1;

      if (w_commit) begin
        r_shadow       <= r_pending;
        r_pending_full <= 1'b0;
      end

      // Ready can only be high with pending empty, so transfer and commit never coincide.
      if (w_transfer) begin
        r_pending      <= value_in;
        r_pending_full <= 1'b1;
        r_load_ready   <= 1'b0;
      end else if (r_commit_p1) begin
        r_load_ready   <= 1'b1;
      end

      // Stage p1: registered pin drive.
      r_anode_p1   <= w_dark ? ANODE_OFF : ~(8'b1 << r_idx);
      r_cathode_p1 <= w_dark ? SEG_OFF : w_seg;
    end
  end

  assign load_ready = r_load_ready;
  assign anode      = r_anode_p1;
  assign cathode    = r_cathode_p1;
  assign frame_done = w_boundary;

endmodule
